// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target: answers 9Fh/05h/03h/0Bh from a synchronous ROM port.
// All SPI pins are resynchronised to clk; clk must run at least 8x sclk.
//
// state    | meaning
// S_IDLE   | deselected, waiting for a cs_n fall
// S_CMD    | shifting in the command byte
// S_ADDR   | shifting in the 3 address bytes
// S_DUMMY  | 8 dummy clocks of a fast read
// S_ID     | returning JEDEC ID bytes, then zeros
// S_STAT   | returning the status byte repeatedly
// S_DATA   | streaming ROM bytes with prefetch
// S_IGNORE | unknown command, stay off the bus until deselect
module spi_flash_responder #(
  parameter int unsigned ADDR_W   = 16,
  parameter logic [23:0] JEDEC_ID = 24'h016017,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              si,
  output logic              so,
  output logic              so_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_ID, S_STAT, S_DATA, S_IGNORE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_sclk_sync;
  logic [1:0]        r_cs_sync;
  logic [1:0]        r_si_sync;
  logic              r_sclk_d;
  logic              r_cs_d;
  logic [2:0]        r_bit_cnt;
  logic [6:0]        r_rx;
  logic [ADDR_W-1:0] r_addr_sh;
  logic [1:0]        r_addr_cnt;
  logic              r_dummy;
  logic [1:0]        r_id_idx;
  logic [7:0]        r_buf;
  logic [7:0]        r_tx;
  logic              r_so;
  logic              r_so_oe;
  logic              r_mem_rd;
  logic              r_rd_d;
  logic [ADDR_W-1:0] r_mem_addr;

  logic              w_sclk;
  logic              w_cs_n;
  logic              w_si;
  logic              w_rise;
  logic              w_fall;
  logic              w_cs_fall;
  logic              w_byte_done;
  logic              w_out_phase;
  logic [7:0]        w_rx_next;
  logic [ADDR_W-1:0] w_addr_next;

  assign w_sclk      = r_sclk_sync[1];
  assign w_cs_n      = r_cs_sync[1];
  assign w_si        = r_si_sync[1];
  assign w_rise      = w_sclk & ~r_sclk_d;
  assign w_fall      = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = r_cs_d & ~w_cs_n;
  assign w_byte_done = w_rise & (r_bit_cnt == 3'd7);
  assign w_rx_next   = {r_rx, w_si};
  // Only the low ADDR_W address bits are kept; the upper ones shift out.
  assign w_addr_next = {r_addr_sh[ADDR_W-2:0], w_si};
  assign w_out_phase = (r_state == S_ID) || (r_state == S_STAT) || (r_state == S_DATA);

  assign so       = r_so;
  assign so_oe    = r_so_oe;
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // cs_n synchroniser resets low so a cs_n already low at release is
      // not mistaken for a fresh select.
      r_state     <= S_IDLE;
      r_sclk_sync <= 2'b00;
      r_cs_sync   <= 2'b00;
      r_si_sync   <= 2'b00;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_rx        <= 7'd0;
      r_addr_sh   <= '0;
      r_addr_cnt  <= 2'd0;
      r_dummy     <= 1'b0;
      r_id_idx    <= 2'd0;
      r_buf       <= 8'h00;
      r_tx        <= 8'h00;
      r_so        <= 1'b1;
      r_so_oe     <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_rd_d      <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], sclk};
      r_cs_sync   <= {r_cs_sync[0], cs_n};
      r_si_sync   <= {r_si_sync[0], si};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs_n;
      r_mem_rd    <= 1'b0;
      r_rd_d      <= r_mem_rd;
      if (r_rd_d) r_buf <= mem_data;

      if (w_cs_n) begin
        r_state    <= S_IDLE;
        r_so       <= 1'b1;
        r_so_oe    <= 1'b0;
        r_bit_cnt  <= 3'd0;
        r_rx       <= 7'd0;
        r_addr_cnt <= 2'd0;
      end else if (r_state == S_IDLE) begin
        if (w_cs_fall) begin
          r_state   <= S_CMD;
          r_bit_cnt <= 3'd0;
          r_rx      <= 7'd0;
        end
      end else begin
        if (w_rise) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_rx      <= w_rx_next[6:0];
          if (r_state == S_ADDR) r_addr_sh <= w_addr_next;
        end

        // First fall of each byte takes the freshly prepared byte from r_buf.
        if (w_fall && w_out_phase) begin
          r_so_oe <= 1'b1;
          if (r_bit_cnt == 3'd0) begin
            r_so <= r_buf[7];
            r_tx <= {r_buf[6:0], 1'b0};
          end else begin
            r_so <= r_tx[7];
            r_tx <= {r_tx[6:0], 1'b0};
          end
        end

        if (w_byte_done) begin
          case (r_state)
            S_CMD: begin
              case (w_rx_next)
                8'h9F: begin
                  r_state  <= S_ID;
                  r_buf    <= JEDEC_ID[23:16];
                  r_id_idx <= 2'd1;
                end
                8'h05: begin
                  r_state <= S_STAT;
                  r_buf   <= STATUS;
                end
                8'h03: begin
                  r_state    <= S_ADDR;
                  r_dummy    <= 1'b0;
                  r_addr_cnt <= 2'd0;
                end
                8'h0B: begin
                  r_state    <= S_ADDR;
                  r_dummy    <= 1'b1;
                  r_addr_cnt <= 2'd0;
                end
                default: r_state <= S_IGNORE;
              endcase
            end
            S_ADDR: begin
              r_addr_cnt <= r_addr_cnt + 2'd1;
              if (r_addr_cnt == 2'd2) begin
                if (r_dummy) begin
                  r_state <= S_DUMMY;
                end else begin
                  r_state    <= S_DATA;
                  r_mem_rd   <= 1'b1;
                  r_mem_addr <= w_addr_next;
                end
              end
            end
            S_DUMMY: begin
              r_state    <= S_DATA;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_addr_sh;
            end
            S_ID: begin
              case (r_id_idx)
                2'd1: begin
                  r_buf    <= JEDEC_ID[15:8];
                  r_id_idx <= 2'd2;
                end
                2'd2: begin
                  r_buf    <= JEDEC_ID[7:0];
                  r_id_idx <= 2'd3;
                end
                default: r_buf <= 8'h00;
              endcase
            end
            S_STAT: r_buf <= STATUS;
            S_DATA: begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: table of SPI transactions with a byte
// scoreboard, plus hand-written ignore, abort and reset sequences.
module tb_spi_flash_responder;
  localparam int ADDR_W = 16;
  localparam int HALF   = 8;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              sclk  = 1'b0;
  logic              cs_n  = 1'b1;
  logic              si    = 1'b0;
  logic              so;
  logic              so_oe;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'h00;

  spi_flash_responder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .si(si),
    .so(so), .so_oe(so_oe), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:65535];
  always @(posedge clk) if (mem_rd) mem_data <= rom[mem_addr];

  int   rd_cnt  = 0;
  int   oe_cnt  = 0;
  int   consec  = 0;
  logic rd_prev = 1'b0;
  always @(posedge clk) begin
    if (mem_rd) rd_cnt++;
    if (so_oe) oe_cnt++;
    if (mem_rd && rd_prev) consec++;
    rd_prev = mem_rd;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          n_addr;
    int          n_dummy;
    int          n_read;
    logic [31:0] exp;
    int          rd_lo;
    int          rd_hi;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master samples so just before raising sclk (mode 0).
  task automatic send_bit(input logic b, output logic r, output logic oe);
    si = b;
    wait_clks(HALF);
    r  = so;
    oe = so_oe;
    sclk = 1'b1;
    wait_clks(HALF);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] r,
                           output logic oe_or, output logic oe_and);
    logic rb;
    logic ob;
    oe_or  = 1'b0;
    oe_and = 1'b1;
    r      = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], rb, ob);
      r[i]   = rb;
      oe_or  = oe_or | ob;
      oe_and = oe_and & ob;
    end
  endtask

  task automatic end_xfer();
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(2 * HALF);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0]  r;
    logic        oe_or;
    logic        oe_and;
    logic        cmd_oe;
    logic        rd_oe;
    logic [23:0] a;
    logic [31:0] e;
    logic [7:0]  exp_b;
    int          rd0;
    rd0    = rd_cnt;
    cmd_oe = 1'b0;
    rd_oe  = 1'b1;
    cs_n = 1'b0;
    wait_clks(HALF);
    send_byte(v.cmd, r, oe_or, oe_and);
    cmd_oe = cmd_oe | oe_or;
    a = v.addr;
    for (int i = 0; i < v.n_addr; i++) begin
      send_byte(a[23:16], r, oe_or, oe_and);
      cmd_oe = cmd_oe | oe_or;
      a = a << 8;
    end
    for (int i = 0; i < v.n_dummy; i++) begin
      send_byte(8'hFF, r, oe_or, oe_and);
      cmd_oe = cmd_oe | oe_or;
    end
    chk({v.name, "_cmd_oe"}, {31'd0, cmd_oe}, 32'd0);
    e = v.exp;
    for (int i = 0; i < v.n_read; i++) begin
      exp_q.push_back(e[31:24]);
      e = e << 8;
      send_byte(8'h00, r, oe_or, oe_and);
      rd_oe = rd_oe & oe_and;
      exp_b = exp_q.pop_front();
      chk($sformatf("%s_byte%0d", v.name, i), {24'd0, r}, {24'd0, exp_b});
    end
    chk({v.name, "_read_oe"}, {31'd0, rd_oe}, 32'd1);
    end_xfer();
    chk_range({v.name, "_mem_rd_pulses"}, rd_cnt - rd0, v.rd_lo, v.rd_hi);
  endtask

  initial begin
    logic [7:0] r;
    logic       ob;
    logic       oe_or;
    logic       oe_and;
    int         oe0;
    vec_t       v;

    for (int i = 0; i < 65536; i++) rom[i] = 8'(i) ^ 8'h96;
    rom[16'h0100] = 8'h11;
    rom[16'h0101] = 8'h22;
    rom[16'h0102] = 8'h33;
    rom[16'h0103] = 8'h44;
    rom[16'hFFFF] = 8'hA5;
    rom[16'h0000] = 8'h5A;
    rom[16'h0001] = 8'h77;
    rom[16'h3456] = 8'hC3;
    rom[16'h3457] = 8'h3C;

    vecs[0] = '{"jedec_id",  8'h9F, 24'h000000, 0, 0, 4, 32'h01601700, 0, 0};
    vecs[1] = '{"read_0100", 8'h03, 24'h000100, 3, 0, 4, 32'h11223344, 4, 5};
    vecs[2] = '{"fast_wrap", 8'h0B, 24'h00FFFF, 3, 1, 2, 32'hA55A0000, 2, 3};
    vecs[3] = '{"status",    8'h05, 24'h000000, 0, 0, 2, 32'h00000000, 0, 0};
    vecs[4] = '{"read_trunc",8'h03, 24'h123456, 3, 0, 2, 32'hC33C0000, 2, 3};

    wait_clks(3);
    chk("reset_so", {31'd0, so}, 32'd1);
    chk("reset_so_oe", {31'd0, so_oe}, 32'd0);
    chk("reset_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
    rst_n = 1'b1;
    wait_clks(4);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Unknown command: bus must stay released for the whole transfer.
    oe0 = oe_cnt;
    cs_n = 1'b0;
    wait_clks(HALF);
    send_byte(8'h3B, r, oe_or, oe_and);
    for (int i = 0; i < 3; i++) send_byte(8'h00, r, oe_or, oe_and);
    end_xfer();
    chk("ignore_oe_cycles", oe_cnt - oe0, 32'd0);
    v = '{"status_after_ignore", 8'h05, 24'h0, 0, 0, 2, 32'h00000000, 0, 0};
    run_vec(v);

    // Deselect after 13 bits of a read command.
    cs_n = 1'b0;
    wait_clks(HALF);
    send_byte(8'h03, r, oe_or, oe_and);
    for (int i = 0; i < 5; i++) send_bit(1'b0, ob, ob);
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(3);
    chk("abort_addr_so_oe", {31'd0, so_oe}, 32'd0);
    chk("abort_addr_so", {31'd0, so}, 32'd1);
    wait_clks(2 * HALF);

    // Deselect mid-way through an ID byte while driving.
    cs_n = 1'b0;
    wait_clks(HALF);
    send_byte(8'h9F, r, oe_or, oe_and);
    for (int i = 0; i < 4; i++) send_bit(1'b0, r[0], ob);
    chk("abort_id_oe_before", {31'd0, ob}, 32'd1);
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(3);
    chk("abort_id_so_oe", {31'd0, so_oe}, 32'd0);
    chk("abort_id_so", {31'd0, so}, 32'd1);
    wait_clks(2 * HALF);
    v = vecs[0];
    v.name = "jedec_after_abort";
    run_vec(v);

    // Reset in the middle of a data byte.
    cs_n = 1'b0;
    wait_clks(HALF);
    send_byte(8'h03, r, oe_or, oe_and);
    send_byte(8'h00, r, oe_or, oe_and);
    send_byte(8'h01, r, oe_or, oe_and);
    send_byte(8'h00, r, oe_or, oe_and);
    send_byte(8'h00, r, oe_or, oe_and);
    chk("pre_reset_byte", {24'd0, r}, 32'h11);
    for (int i = 0; i < 3; i++) send_bit(1'b0, ob, ob);
    chk("pre_reset_mem_addr", {16'd0, mem_addr}, 32'h0101);
    wait_clks(2);
    rst_n = 1'b0;
    #1;
    chk("rst_so", {31'd0, so}, 32'd1);
    chk("rst_so_oe", {31'd0, so_oe}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);
    oe0 = oe_cnt;
    send_byte(8'h05, r, oe_or, oe_and);
    send_byte(8'h00, r, oe_or, oe_and);
    chk("no_fresh_fall_oe", oe_cnt - oe0, 32'd0);
    cs_n = 1'b1;
    wait_clks(2 * HALF);
    v = '{"boot_read", 8'h03, 24'h000000, 3, 0, 2, 32'h5A770000, 2, 3};
    run_vec(v);

    chk("mem_rd_back_to_back", consec, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
